// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared types and defaults for the clk_sched tick scheduler
// Optional re-phase feature is selected by CLK_SCHED_SYNC_EN.
package clk_sched_pkg;

  localparam int CH_NUM_DEF = 4;
  localparam int DIV_W_DEF  = 16;
  localparam int CH_W_MAX   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [DIV_W_DEF-1:0] div;
    logic                 run;
  } cfg_t;

  function automatic int ch_width(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/clk_sched_channel.sv
// rtl/clk_sched_channel.sv - one tick channel: down-counter, pending ratio slot, run state
// i_sync exists only when CLK_SCHED_SYNC_EN is defined.
module clk_sched_channel
  import clk_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_run,
`ifdef CLK_SCHED_SYNC_EN
  input  logic             i_sync,
`endif
  output logic             o_tick,
  output logic             o_busy,
  output logic             o_pend_v
);

  ch_state_e        r_state, w_state;
  logic [DIV_W-1:0] r_cnt, w_cnt;
  logic [DIV_W-1:0] r_div_cur, w_div_cur;
  logic [DIV_W-1:0] r_pend_div, w_pend_div;
  logic             r_pend_v, w_pend_v;
  logic             r_tick, w_tick;
  logic [DIV_W-1:0] w_div_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div_cur  <= '0;
      r_pend_div <= '0;
      r_pend_v   <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_div_cur  <= w_div_cur;
      r_pend_div <= w_pend_div;
      r_pend_v   <= w_pend_v;
      r_tick     <= w_tick;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_div_cur  = r_div_cur;
    w_pend_div = r_pend_div;
    w_pend_v   = r_pend_v;
    w_tick     = 1'b0;
    w_div_eff  = r_pend_v ? r_pend_div : r_div_cur;

    if (r_state == RUN) begin
      if (r_cnt == '0) begin
        w_tick    = 1'b1;
        w_cnt     = w_div_eff - DIV_W'(1);
        w_div_cur = w_div_eff;
        w_pend_v  = 1'b0;
      end else begin
        w_cnt = r_cnt - DIV_W'(1);
      end
`ifdef CLK_SCHED_SYNC_EN
      if (i_sync) begin
        w_tick    = 1'b0;
        w_cnt     = w_div_eff - DIV_W'(1);
        w_div_cur = w_div_eff;
        w_pend_v  = 1'b0;
      end
`endif
    end

    // A config write is applied last so it wins over counting and sync.
    if (i_wr) begin
      if (i_run && (i_div != '0)) begin
        if (r_state == IDLE) begin
          w_state   = RUN;
          w_div_cur = i_div;
          w_cnt     = i_div - DIV_W'(1);
          w_tick    = 1'b0;
        end else if (r_cnt == '0) begin
          w_cnt     = i_div - DIV_W'(1);
          w_div_cur = i_div;
          w_tick    = 1'b1;
          w_pend_v  = 1'b0;
        end else begin
          w_pend_div = i_div;
          w_pend_v   = 1'b1;
        end
      end else if (r_state == RUN) begin
        w_state  = IDLE;
        w_cnt    = '0;
        w_pend_v = 1'b0;
        w_tick   = 1'b0;
      end
    end
  end

  assign o_tick   = r_tick;
  assign o_busy   = (r_state == RUN);
  assign o_pend_v = r_pend_v;

endmodule

// File: rtl/clk_sched.sv
// rtl/clk_sched.sv - CH_NUM programmable tick-strobe scheduler with valid/ready config port
// Defining CLK_SCHED_SYNC_EN adds the sync_in re-phase input.
module clk_sched
  import clk_sched_pkg::*;
#(
  parameter  int CH_NUM = CH_NUM_DEF,
  parameter  int DIV_W  = DIV_W_DEF,
  localparam int CH_W   = ch_width(CH_NUM)
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_run,
`ifdef CLK_SCHED_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [CH_NUM-1:0] tick,
  output logic [CH_NUM-1:0] busy
);

  logic [CH_NUM-1:0] w_pend_v;
  logic [CH_NUM-1:0] w_wr;

  // Out-of-range channels match nothing, so they stay ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !w_pend_v[i];
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign w_wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clk_sched_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk      (clk_50MHz),
      .rst_n    (rst_n),
      .i_wr     (w_wr[g]),
      .i_div    (cfg_div),
      .i_run    (cfg_run),
`ifdef CLK_SCHED_SYNC_EN
      .i_sync   (sync_in),
`endif
      .o_tick   (tick[g]),
      .o_busy   (busy[g]),
      .o_pend_v (w_pend_v[g])
    );
  end

endmodule
